// File: rtl/multiply_unit_64_pkg.sv
// Shared widths, state encoding and helpers for the
// shift-add multiplier and its register file.
package multiply_unit_64_pkg;

  localparam int N_DEF = 32;
  localparam int M_DEF = 64;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  function automatic int log2w(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/multiply_unit_64_if.sv
// Request/result bundle between the register file
// and the multiplier.
interface multiply_unit_64_if
  import multiply_unit_64_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int m = M_DEF
);

  localparam int AW = log2w(n);

  logic          start;
  logic [m-1:0]  A;
  logic [m-1:0]  B;
  logic [AW-1:0] dest;
  logic          busy;
  logic [m-1:0]  D;
  logic [AW-1:0] DA;
  logic          WR;

  modport master (
    output start, A, B, dest,
    input  busy, D, DA, WR
  );

  modport slave (
    input  start, A, B, dest,
    output busy, D, DA, WR
  );

endinterface

// File: rtl/mult_datapath_64.sv
// Operand, accumulator and result registers with the
// single adder used once per RUN iteration.
module mult_datapath_64
  import multiply_unit_64_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int m = M_DEF,
  localparam int AW = log2w(n)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          commit,
  input  logic [m-1:0]  a,
  input  logic [m-1:0]  b,
  input  logic [AW-1:0] dest,
  output logic [m-1:0]  d,
  output logic [AW-1:0] da
);

  logic [m-1:0]  mcand;
  logic [m-1:0]  mplier;
  logic [m-1:0]  acc;
  logic [m-1:0]  acc_nx;
  logic [AW-1:0] dst;

  // carry out of the adder is dropped: low m bits only
  assign acc_nx = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      dst    <= '0;
      d      <= '0;
      da     <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      dst    <= dest;
    end else if (step) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (commit) begin
        d  <= acc_nx;
        da <= dst;
      end
    end
  end

endmodule

// File: rtl/multiply_unit_64.sv
// MUL unit: fixed m-cycle shift-add multiply feeding
// the register file write port.
module multiply_unit_64
  import multiply_unit_64_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int m = M_DEF
) (
  input  logic clock,
  input  logic reset,
  multiply_unit_64_if.slave bus
);

  localparam int CW = log2w(m);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] cnt;
  logic          is_idle;
  logic          is_run;
  logic          is_write;
  logic          last;
  logic          load;

  // unused encoding 3 behaves as IDLE
  assign is_run   = (state == RUN);
  assign is_write = (state == WRITE);
  assign is_idle  = !(is_run || is_write);
  assign last     = is_run && (cnt == CW'(m - 1));
  assign load     = is_idle && bus.start;

  always_comb begin
    state_nx = IDLE;
    unique case (1'b1)
      is_idle:  state_nx = bus.start ? RUN : IDLE;
      is_run:   state_nx = last ? WRITE : RUN;
      is_write: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load)
        cnt <= '0;
      else if (is_run)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.busy = is_run || is_write;
  assign bus.WR   = is_write;

  mult_datapath_64 #(
    .n(n),
    .m(m)
  ) u_dp (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .step  (is_run),
    .commit(last),
    .a     (bus.A),
    .b     (bus.B),
    .dest  (bus.dest),
    .d     (bus.D),
    .da    (bus.DA)
  );

endmodule
